// File: rtl/weight_preload_sequencer_pkg.sv
// Shared types and default configuration for the weight preload sequencer and the mesh top.
package weight_preload_sequencer_pkg;

    localparam int unsigned DW_DEF         = 8;
    localparam int unsigned ROWS_DEF       = 8;
    localparam int unsigned COLS_DEF       = 2;
    localparam int unsigned ROW_W_DEF      = 3;
    localparam int unsigned COL_W_DEF      = 1;
    localparam int unsigned RUN_CYCLES_DEF = 12;
    localparam int unsigned CNT_W_DEF      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFire,
        StRun
    } state_e;

    // Mesh write address is row-major: row in the upper bits, column in the lower bits.
    function automatic logic [ROW_W_DEF+COL_W_DEF-1:0] pack_addr(
        input logic [ROW_W_DEF-1:0] row,
        input logic [COL_W_DEF-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/weight_preload_sequencer_if.sv
// Ready/valid weight byte stream between the host DMA and the preload sequencer.
interface weight_preload_sequencer_if
    import weight_preload_sequencer_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) ();

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/weight_preload_sequencer_rowcol_counter.sv
// Nested row/column position counter; column is the fast index. Flags the final position.
module weight_preload_sequencer_rowcol_counter #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 2,
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] RowMax = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] ColMax = COL_W'(COLS - 1);

    // Advance column first, carry into row; wrap at the final position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == ColMax) begin
                col <= '0;
                row <= (row == RowMax) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Final position of the mesh.
    always_comb begin
        last = (row == RowMax) && (col == ColMax);
    end

endmodule

// File: rtl/weight_preload_sequencer.sv
// Converts a ready/valid weight stream into mesh preload writes, then starts the mesh and
// times its fixed compute window.
module weight_preload_sequencer
    import weight_preload_sequencer_pkg::*;
#(
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned ROWS       = ROWS_DEF,
    parameter int unsigned COLS       = COLS_DEF,
    parameter int unsigned ROW_W      = ROW_W_DEF,
    parameter int unsigned COL_W      = COL_W_DEF,
    parameter int unsigned RUN_CYCLES = RUN_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_req,
    weight_preload_sequencer_if.slave stream,
    output logic                   preload_valid,
    output logic [ROW_W+COL_W-1:0] preload_addr,
    output logic [DW-1:0]          preload_data,
    output logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [CNT_W-1:0] RunLast = CNT_W'(RUN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last_pos;
    logic             s_ready;
    logic             accept;
    logic             load_go;
    logic [CNT_W-1:0] cnt_q;

    assign stream.s_ready = s_ready;
    assign accept         = s_ready & stream.s_valid;

    weight_preload_sequencer_rowcol_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_rowcol (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_go),
        .inc  (accept),
        .row  (row),
        .col  (col),
        .last (last_pos)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; ready, start, done and busy depend on state only (plus run count).
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        load_go = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    load_go = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (stream.s_valid && last_pos) begin
                    state_d = StFire;
                end
            end
            StFire: begin
                // Coincides with the final registered write strobe.
                start   = 1'b1;
                busy    = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (cnt_q == RunLast) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered write port: one beat per accepted weight, address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preload_valid <= 1'b0;
            preload_addr  <= '0;
            preload_data  <= '0;
        end else begin
            preload_valid <= accept;
            if (accept) begin
                preload_addr <= {row, col};
                preload_data <= stream.s_data;
            end
        end
    end

    // Sticky framing error: s_last must mark exactly the final position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (load_go) begin
            err <= 1'b0;
        end else if (accept && (stream.s_last != last_pos)) begin
            err <= 1'b1;
        end
    end

    // Compute window counter, zeroed while firing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == StFire) begin
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_preload_sequencer.sv
// Scoreboard bench: jobs push expected writes/start/done; a negedge monitor pops and compares.
module tb_weight_preload_sequencer;

    localparam int RUN_CYCLES = 12;

    typedef struct {
        logic [1:0] kind;  // 0 write, 1 start, 2 done
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       load_req;
    logic       preload_valid;
    logic [3:0] preload_addr;
    logic [7:0] preload_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;

    weight_preload_sequencer_if #(.DW(8)) sif ();

    weight_preload_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .load_req      (load_req),
        .stream        (sif.slave),
        .preload_valid (preload_valid),
        .preload_addr  (preload_addr),
        .preload_data  (preload_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    int  cyc       = 0;
    int  start_cyc = 0;
    ev_t exp_q[$];
    ev_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
    endtask

    task automatic push(input logic [1:0] kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: sample outputs mid-cycle, compare against the scoreboard head.
    always @(negedge clk) begin
        if (preload_valid) begin
            if (exp_q.size() == 0) fail_now("write_unexpected");
            else begin
                mon_e = exp_q.pop_front();
                check("write", {18'd0, mon_e.kind, mon_e.addr, mon_e.data},
                      {18'd0, 2'd0, preload_addr, preload_data});
            end
        end
        if (start) begin
            start_cyc = cyc;
            if (exp_q.size() == 0) fail_now("start_unexpected");
            else begin
                mon_e = exp_q.pop_front();
                check("start_kind", {30'd0, mon_e.kind}, 32'd1);
                check("start_with_last_write", {27'd0, preload_valid, preload_addr}, 32'h1F);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) fail_now("done_unexpected");
            else begin
                mon_e = exp_q.pop_front();
                check("done_kind", {30'd0, mon_e.kind}, 32'd2);
                check("done_latency", cyc - start_cyc, RUN_CYCLES);
            end
        end
    end

    task automatic pulse_load();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    // Hold the current beat until an edge where s_ready was high.
    task automatic wait_accept();
        bit acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = sif.s_ready;
            @(posedge clk); #1;
        end
        if (!acc) fail_now("beat_accept");
    endtask

    task automatic wait_done(input logic exp_err);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
        else begin
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
            check("err_after_job", {31'd0, err}, {31'd0, exp_err});
        end
    endtask

    task automatic run_job(input logic [7:0] d[16], input int last_pos, input bit bursty,
                           input bit poke, input logic exp_err);
        for (int i = 0; i < 16; i++) push(2'd0, 4'(i), d[i]);
        push(2'd1, 4'd0, 8'd0);
        push(2'd2, 4'd0, 8'd0);
        pulse_load();
        check("busy_on_accept", {31'd0, busy}, 32'd1);
        check("err_cleared_on_load", {31'd0, err}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (bursty && i > 0) begin
                sif.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            sif.s_valid = 1'b1;
            sif.s_data  = d[i];
            sif.s_last  = (i == last_pos);
            wait_accept();
            if (i == last_pos && last_pos < 15) check("err_early_last", {31'd0, err}, 32'd1);
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        if (poke) begin
            @(posedge clk); #1 load_req = 1'b1;
            @(posedge clk); #1 load_req = 1'b0;
            check("load_req_in_run_ignored", {30'd0, busy, sif.s_ready}, 32'd2);
        end
        wait_done(exp_err);
    endtask

    logic [7:0] d_inc[16];
    logic [7:0] d_sgn[16];
    logic [7:0] d_dec[16];
    logic [7:0] sgn_pat[3];

    initial begin
        rst         = 1'b1;
        load_req    = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 8'd0;
        sif.s_last  = 1'b0;
        sgn_pat[0]  = 8'h80;
        sgn_pat[1]  = 8'hFF;
        sgn_pat[2]  = 8'h7F;
        for (int i = 0; i < 16; i++) begin
            d_inc[i] = 8'(i + 1);
            d_sgn[i] = sgn_pat[i % 3];
            d_dec[i] = 8'(8'hF0 - i);
        end

        #1 check("reset_outputs", {15'd0, sif.s_ready, preload_valid, preload_addr, preload_data,
                 start, busy, done, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-load after five accepted beats.
        for (int i = 0; i < 5; i++) push(2'd0, 4'(i), 8'(8'h11 * (i + 1)));
        pulse_load();
        for (int i = 0; i < 5; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = 8'(8'h11 * (i + 1));
            wait_accept();
        end
        sif.s_valid = 1'b0;
        @(posedge clk); #1;
        check("writes_before_reset", exp_q.size(), 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("reset_mid_load", {15'd0, sif.s_ready, preload_valid, preload_addr, preload_data,
                 start, busy, done, err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_job(d_inc, 15, 1'b0, 1'b0, 1'b0);  // continuous 1..16, restart at addr 0
        run_job(d_sgn, 15, 1'b1, 1'b0, 1'b0);  // bursty, signed extremes
        run_job(d_inc, 9,  1'b0, 1'b0, 1'b1);  // s_last early on 10th beat
        run_job(d_dec, 15, 1'b0, 1'b1, 1'b0);  // back-to-back load, load_req poked in run
        run_job(d_inc, -1, 1'b1, 1'b0, 1'b1);  // s_last missing

        repeat (5) @(posedge clk);
        #1 check("scoreboard_drained", exp_q.size(), 32'd0);
        check("idle_at_end", {30'd0, busy, sif.s_ready}, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
